elevator_car_controller: RTL and testbench



---
 rtl/elevator_car_controller_if.sv | 33 +++
 rtl/elevator_car_controller.sv | 171 +++++++++++++++++
 tb/tb_elevator_car_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/elevator_car_controller_if.sv
// Panel/sensor bundle between the three-floor car controller and its environment.
// The master side drives buttons and sensors; the slave (controller) drives the LEDs.
interface elevator_car_controller_if;
   logic st_floor_button;
   logic nd_floor_button;
   logic rd_floor_button;
   logic sos_button;
   logic weight_sensor;
   logic st_floor_led;
   logic nd_floor_led;
   logic rd_floor_led;
   logic st_floor_indicator;
   logic nd_floor_indicator;
   logic rd_floor_indicator;
   logic door_status_led;
   logic weight_led;
   logic sos_led;
   logic emergency_led;

   modport master (
      output st_floor_button, nd_floor_button, rd_floor_button, sos_button, weight_sensor,
      input  st_floor_led, nd_floor_led, rd_floor_led,
      input  st_floor_indicator, nd_floor_indicator, rd_floor_indicator,
      input  door_status_led, weight_led, sos_led, emergency_led
   );

   modport slave (
      input  st_floor_button, nd_floor_button, rd_floor_button, sos_button, weight_sensor,
      output st_floor_led, nd_floor_led, rd_floor_led,
      output st_floor_indicator, nd_floor_indicator, rd_floor_indicator,
      output door_status_led, weight_led, sos_led, emergency_led
   );
endinterface

// File: rtl/elevator_car_controller.sv
// Three-floor elevator car sequencer: latches calls, moves the car floor by floor,
// runs the door timer and freezes everything while an SOS emergency is active.
module elevator_car_controller #(
   parameter int TRAVEL_TICKS = 4,
   parameter int DOOR_TICKS   = 3
) (
   input logic                      clk,
   input logic                      rst_n,
   elevator_car_controller_if.slave io_panel
);
   localparam int MW = $clog2(TRAVEL_TICKS);
   localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_MOVING_UP, S_MOVING_DOWN, S_DOOR_OPEN, S_EMERGENCY
   } state_t;

   state_t          r_state, w_state_nx, r_ret_state, w_ret_nx;
   logic [2:0]      r_floor, w_floor_nx;
   logic [2:0]      r_req, w_req_nx;
   logic [2:0]      w_btn, w_latch, w_clear, w_arr_floor;
   logic            r_dir_up, w_dir_nx;
   logic            r_door, w_door_nx;
   logic            r_weight, r_sos;
   logic [MW-1:0]   r_move_cnt, w_move_nx;
   logic [DW-1:0]   r_door_cnt, w_door_cnt_nx;
   logic            w_sos_edge, w_weight;
   logic            w_here_req, w_here_btn, w_above, w_below;
   logic            w_move_done, w_door_done, w_go_up;

   // Floors are one-hot: bit0 = floor 1, bit2 = floor 3.
   function automatic logic req_above(input logic [2:0] f, input logic [2:0] r);
      return (f[0] & (r[1] | r[2])) | (f[1] & r[2]);
   endfunction

   function automatic logic req_below(input logic [2:0] f, input logic [2:0] r);
      return (f[2] & (r[1] | r[0])) | (f[1] & r[0]);
   endfunction

   assign w_btn       = {io_panel.rd_floor_button, io_panel.nd_floor_button, io_panel.st_floor_button};
   assign w_weight    = io_panel.weight_sensor;
   assign w_sos_edge  = io_panel.sos_button & ~r_sos;
   assign w_here_req  = |(r_req & r_floor);
   assign w_here_btn  = |(w_btn & r_floor);
   assign w_above     = req_above(r_floor, r_req);
   assign w_below     = req_below(r_floor, r_req);
   assign w_go_up     = r_dir_up ? w_above : ~w_below;
   assign w_move_done = (r_move_cnt == MW'(TRAVEL_TICKS - 1));
   assign w_door_done = (r_door_cnt == DW'(DOOR_TICKS - 1));

   always_comb begin
      w_state_nx    = r_state;
      w_ret_nx      = r_ret_state;
      w_floor_nx    = r_floor;
      w_dir_nx      = r_dir_up;
      w_door_nx     = r_door;
      w_move_nx     = r_move_cnt;
      w_door_cnt_nx = r_door_cnt;
      w_clear       = 3'b000;
      w_latch       = w_btn;
      if (r_state == S_IDLE || r_state == S_DOOR_OPEN)
         w_latch = w_btn & ~r_floor;
      // Saturating one-floor step in the current travel direction.
      if (r_state == S_MOVING_UP)
         w_arr_floor = {r_floor[1:0], 1'b0} | (r_floor & 3'b100);
      else
         w_arr_floor = {1'b0, r_floor[2:1]} | (r_floor & 3'b001);

      if (w_sos_edge) begin
         if (r_state == S_EMERGENCY) begin
            w_state_nx = r_ret_state;
         end else begin
            w_ret_nx   = r_state;
            w_state_nx = S_EMERGENCY;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_weight) begin
                  if (w_here_req || w_here_btn) begin
                     w_state_nx    = S_DOOR_OPEN;
                     w_clear       = r_floor;
                     w_door_nx     = 1'b1;
                     w_door_cnt_nx = '0;
                  end else if (w_above || w_below) begin
                     w_dir_nx   = w_go_up;
                     w_state_nx = w_go_up ? S_MOVING_UP : S_MOVING_DOWN;
                     w_move_nx  = '0;
                  end
               end
            end
            S_MOVING_UP, S_MOVING_DOWN: begin
               if (w_move_done) begin
                  w_move_nx  = '0;
                  w_floor_nx = w_arr_floor;
                  if (w_arr_floor[0])      w_dir_nx = 1'b1;
                  else if (w_arr_floor[2]) w_dir_nx = 1'b0;
                  if (|(r_req & w_arr_floor)) begin
                     w_state_nx    = S_DOOR_OPEN;
                     w_clear       = w_arr_floor;
                     w_door_nx     = 1'b1;
                     w_door_cnt_nx = '0;
                  end else if (!((r_state == S_MOVING_UP) ? req_above(w_arr_floor, r_req)
                                                          : req_below(w_arr_floor, r_req))) begin
                     w_state_nx = S_IDLE;
                  end
               end else begin
                  w_move_nx = r_move_cnt + 1'b1;
               end
            end
            S_DOOR_OPEN: begin
               if (w_here_btn) begin
                  w_door_cnt_nx = '0;
               end else if (w_door_done) begin
                  // An overloaded car holds the door at expiry until the weight drops.
                  if (!w_weight) begin
                     w_state_nx = S_IDLE;
                     w_door_nx  = 1'b0;
                  end
               end else begin
                  w_door_cnt_nx = r_door_cnt + 1'b1;
               end
            end
            S_EMERGENCY: begin
               w_state_nx = S_EMERGENCY;
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
      w_req_nx = (r_req | w_latch) & ~w_clear;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ret_state <= S_IDLE;
         r_floor     <= 3'b001;
         r_req       <= 3'b000;
         r_dir_up    <= 1'b1;
         r_door      <= 1'b0;
         r_weight    <= 1'b0;
         r_sos       <= 1'b0;
         r_move_cnt  <= '0;
         r_door_cnt  <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_ret_state <= w_ret_nx;
         r_floor     <= w_floor_nx;
         r_req       <= w_req_nx;
         r_dir_up    <= w_dir_nx;
         r_door      <= w_door_nx;
         r_weight    <= w_weight;
         r_sos       <= io_panel.sos_button;
         r_move_cnt  <= w_move_nx;
         r_door_cnt  <= w_door_cnt_nx;
      end
   end

   assign io_panel.st_floor_led       = r_req[0];
   assign io_panel.nd_floor_led       = r_req[1];
   assign io_panel.rd_floor_led       = r_req[2];
   assign io_panel.st_floor_indicator = r_floor[0];
   assign io_panel.nd_floor_indicator = r_floor[1];
   assign io_panel.rd_floor_indicator = r_floor[2];
   assign io_panel.door_status_led    = r_door;
   assign io_panel.weight_led         = r_weight;
   assign io_panel.sos_led            = r_sos;
   assign io_panel.emergency_led      = (r_state == S_EMERGENCY);
endmodule

// File: tb/tb_elevator_car_controller.sv
// Randomized bench for the elevator car controller against a floor-number reference model.
module tb_elevator_car_controller;
   localparam int TT = 4;
   localparam int DT = 3;
   localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_EMER = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   elevator_car_controller_if pif ();

   elevator_car_controller #(.TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io_panel (pif.slave)
   );

   always #5 clk = ~clk;

   // Reference model: floor is 1..3, requests indexed by floor number.
   int m_floor, m_mode, m_saved, m_mcnt, m_dcnt;
   bit m_up, m_door, m_wt, m_sos;
   bit m_req[1:3];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_floor = 1; m_mode = M_IDLE; m_saved = M_IDLE; m_mcnt = 0; m_dcnt = 0;
      m_up = 1'b1; m_door = 1'b0; m_wt = 1'b0; m_sos = 1'b0;
      for (int f = 1; f <= 3; f++) m_req[f] = 1'b0;
   endtask

   function automatic bit pending(input int from, input int dir);
      for (int g = from + dir; g >= 1 && g <= 3; g += dir)
         if (m_req[g]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input bit b1, input bit b2, input bit b3, input bit sos, input bit wt);
      bit b[1:3];
      bit nreq[1:3];
      bit sos_rise;
      int nf, d;
      b[1] = b1; b[2] = b2; b[3] = b3;
      sos_rise = sos && !m_sos;
      for (int f = 1; f <= 3; f++) begin
         nreq[f] = m_req[f] | b[f];
         if ((m_mode == M_IDLE || m_mode == M_DOOR) && f == m_floor) nreq[f] = m_req[f];
      end
      if (sos_rise) begin
         if (m_mode == M_EMER) m_mode = m_saved;
         else begin m_saved = m_mode; m_mode = M_EMER; end
      end else begin
         case (m_mode)
            M_IDLE: if (!wt) begin
               if (m_req[m_floor] || b[m_floor]) begin
                  m_mode = M_DOOR; nreq[m_floor] = 1'b0; m_door = 1'b1; m_dcnt = 0;
               end else if (pending(m_floor, 1) || pending(m_floor, -1)) begin
                  if (m_up) m_up = pending(m_floor, 1);
                  else      m_up = !pending(m_floor, -1);
                  m_mode = m_up ? M_UP : M_DOWN;
                  m_mcnt = 0;
               end
            end
            M_UP, M_DOWN: begin
               if (m_mcnt == TT - 1) begin
                  d = (m_mode == M_UP) ? 1 : -1;
                  nf = m_floor + d;
                  if (nf < 1) nf = 1;
                  if (nf > 3) nf = 3;
                  m_mcnt = 0;
                  m_floor = nf;
                  if (nf == 1) m_up = 1'b1;
                  if (nf == 3) m_up = 1'b0;
                  if (m_req[nf]) begin
                     m_mode = M_DOOR; nreq[nf] = 1'b0; m_door = 1'b1; m_dcnt = 0;
                  end else if (!pending(nf, d)) begin
                     m_mode = M_IDLE;
                  end
               end else begin
                  m_mcnt++;
               end
            end
            M_DOOR: begin
               if (b[m_floor]) m_dcnt = 0;
               else if (m_dcnt == DT - 1) begin
                  if (!wt) begin m_mode = M_IDLE; m_door = 1'b0; end
               end else m_dcnt++;
            end
            default: ;
         endcase
      end
      m_req = nreq;
      m_sos = sos;
      m_wt  = wt;
   endtask

   task automatic check_outputs();
      logic [2:0] exp_floor;
      exp_floor = 3'b001 << (m_floor - 1);
      check_val("floor", {pif.rd_floor_indicator, pif.nd_floor_indicator, pif.st_floor_indicator}, exp_floor);
      check_val("calls", {pif.rd_floor_led, pif.nd_floor_led, pif.st_floor_led}, {m_req[3], m_req[2], m_req[1]});
      check_val("door", pif.door_status_led, m_door);
      check_val("stat", {pif.weight_led, pif.sos_led, pif.emergency_led}, {m_wt, m_sos, m_mode == M_EMER});
   endtask

   // Apply inputs just after a falling edge, let the rising edge act, check on the next falling edge.
   task automatic cycle(input bit b1, input bit b2, input bit b3, input bit sos, input bit wt);
      pif.st_floor_button = b1;
      pif.nd_floor_button = b2;
      pif.rd_floor_button = b3;
      pif.sos_button      = sos;
      pif.weight_sensor   = wt;
      model_step(b1, b2, b3, sos, wt);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic random_run(input int n);
      bit sos_lvl, wt_lvl;
      sos_lvl = 1'b0;
      wt_lvl  = 1'b0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 39) == 0) sos_lvl = !sos_lvl;
         if (wt_lvl ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0)) wt_lvl = !wt_lvl;
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0, sos_lvl, wt_lvl);
      end
   endtask

   initial begin
      pif.st_floor_button = 1'b0;
      pif.nd_floor_button = 1'b0;
      pif.rd_floor_button = 1'b0;
      pif.sos_button      = 1'b0;
      pif.weight_sensor   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_floor", {pif.rd_floor_indicator, pif.nd_floor_indicator, pif.st_floor_indicator}, 3'b001);
      check_val("rst_leds", {pif.rd_floor_led, pif.nd_floor_led, pif.st_floor_led, pif.door_status_led,
                             pif.weight_led, pif.sos_led, pif.emergency_led}, 7'd0);
      rst_n = 1'b1;

      // Single call to floor 3 from floor 1.
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("rd_led_e1", pif.rd_floor_led, 1'b1);
      for (int k = 2; k <= 13; k++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (k == 5)  check_val("ind_e5", {pif.rd_floor_indicator, pif.nd_floor_indicator, pif.st_floor_indicator}, 3'b001);
         if (k == 6)  check_val("ind_e6", {pif.rd_floor_indicator, pif.nd_floor_indicator, pif.st_floor_indicator}, 3'b010);
         if (k == 10) check_val("arr_e10", {pif.rd_floor_indicator, pif.door_status_led, pif.rd_floor_led}, 3'b110);
         if (k == 12) check_val("door_e12", pif.door_status_led, 1'b1);
         if (k == 13) check_val("door_e13", pif.door_status_led, 1'b0);
      end

      random_run(1500);

      // Asynchronous reset between edges, then a quiet stretch.
      pif.st_floor_button = 1'b0;
      pif.nd_floor_button = 1'b0;
      pif.rd_floor_button = 1'b0;
      pif.sos_button      = 1'b0;
      pif.weight_sensor   = 1'b0;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_val("async_floor", {pif.rd_floor_indicator, pif.nd_floor_indicator, pif.st_floor_indicator}, 3'b001);
      check_val("async_leds", {pif.rd_floor_led, pif.nd_floor_led, pif.st_floor_led, pif.door_status_led,
                               pif.weight_led, pif.sos_led, pif.emergency_led}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      random_run(1500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
